// File: rtl/kgprisc_dmem_arbiter.sv
// rtl/kgprisc_dmem_arbiter.sv - round-robin data-memory arbiter, CPU port 0 vs loader/debug port 1
// Port 1 may hold a bounded burst lock; read data returns one cycle after the grant.
module kgprisc_dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              cpu_stall,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [15:0]       conflict_cnt
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic        last_gnt;
  logic        lock_active;
  logic [3:0]  burst_cnt;
  logic        rd_pend;
  logic        rd_owner;

  logic        last_gnt_nxt;
  logic        lock_active_nxt;
  logic [3:0]  burst_cnt_nxt;
  logic        rd_pend_nxt;
  logic        rd_owner_nxt;
  logic [15:0] conflict_cnt_nxt;
  logic        contended;

  assign contended = m0_req & m1_req;

  // Grant decision; everything is held off while reset is asserted.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      if (contended) begin
        if (lock_active && (burst_cnt < MAX_B)) begin
          m1_gnt = 1'b1;
        end else if (last_gnt) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = 1'b1;
        end
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = m0_req & ~m0_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_comb begin
    last_gnt_nxt     = last_gnt;
    lock_active_nxt  = 1'b0;
    burst_cnt_nxt    = 4'd0;
    rd_pend_nxt      = 1'b0;
    rd_owner_nxt     = rd_owner;
    conflict_cnt_nxt = conflict_cnt;

    if (m0_gnt) begin
      last_gnt_nxt = 1'b0;
    end else if (m1_gnt) begin
      last_gnt_nxt = 1'b1;
    end

    // Burst counter saturates so a long uncontended locked burst cannot wrap.
    if (m1_gnt && m1_lock) begin
      lock_active_nxt = 1'b1;
      burst_cnt_nxt   = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
    end

    if (m0_gnt && !m0_we) begin
      rd_pend_nxt  = 1'b1;
      rd_owner_nxt = 1'b0;
    end else if (m1_gnt && !m1_we) begin
      rd_pend_nxt  = 1'b1;
      rd_owner_nxt = 1'b1;
    end

    if (contended && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt_nxt = conflict_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt     <= 1'b1;
      lock_active  <= 1'b0;
      burst_cnt    <= 4'd0;
      rd_pend      <= 1'b0;
      rd_owner     <= 1'b0;
      conflict_cnt <= 16'd0;
    end else begin
      last_gnt     <= last_gnt_nxt;
      lock_active  <= lock_active_nxt;
      burst_cnt    <= burst_cnt_nxt;
      rd_pend      <= rd_pend_nxt;
      rd_owner     <= rd_owner_nxt;
      conflict_cnt <= conflict_cnt_nxt;
    end
  end

  assign m0_rvalid = rd_pend & ~rd_owner;
  assign m1_rvalid = rd_pend & rd_owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_kgprisc_dmem_arbiter.sv
// tb/tb_kgprisc_dmem_arbiter.sv - vector-table bench for kgprisc_dmem_arbiter
module tb_kgprisc_dmem_arbiter;

  localparam logic [31:0] D5 = 32'hDEADBEEF;
  localparam logic [31:0] D6 = 32'hCAFE0006;
  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0000;
  localparam logic [31:0] DW = 32'h12345678;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [9:0]  m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [9:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        cpu_stall, mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kgprisc_dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Write-first single-port BRAM model
  logic [31:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[5] = D5;
    mem[6] = D6;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          mem_rdata <= mem_wdata;
        end else begin
          mem_rdata <= mem[mem_addr];
        end
      end
    end
  end

  typedef struct {
    logic        rs;
    logic        r0, w0;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic        lk;
    logic        g0, g1, v0, v1;
    logic [31:0] rd0, rd1;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, r0, w0, input logic [9:0] a0, input logic [31:0] d0,
                     input logic r1, w1, input logic [9:0] a1, input logic [31:0] d1,
                     input logic lk, g0, g1, v0, v1, input logic [31:0] rd0, rd1,
                     input logic [15:0] cnt);
    vec_t v;
    v.rs = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.lk = lk;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    m0_req = 1; m0_addr = 10'd5; m0_wdata = W0;
    m1_req = 1; m1_addr = 10'd6; m1_wdata = W1;

    //   rs r0 w0 a0 d0   r1 w1 a1 d1     lk g0 g1 v0 v1 rd0 rd1 cnt
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    0, 1, 0, 0, 0, 0,  0,  0);   // first tie -> m0
    add(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 1, 0, D5, 0,  1);
    add(1, 1, 0, 5, W0,  0, 0, 0, 0,     0, 1, 0, 0, 0, 0,  0,  1);   // single read
    add(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 1, 0, D5, 0,  1);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 0,  0,  0);   // reset before round robin
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    0, 1, 0, 0, 0, 0,  0,  0);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    0, 0, 1, 1, 0, D5, 0,  1);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    0, 1, 0, 0, 1, 0,  D6, 2);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    0, 0, 1, 1, 0, D5, 0,  3);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    0, 1, 0, 0, 1, 0,  D6, 4);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    0, 0, 1, 1, 0, D5, 0,  5);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 1, 0,  D6, 6);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    1, 1, 0, 0, 0, 0,  0,  6);   // burst lock
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    1, 0, 1, 1, 0, D5, 0,  7);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    1, 0, 1, 0, 1, 0,  D6, 8);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    1, 0, 1, 0, 1, 0,  D6, 9);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    1, 0, 1, 0, 1, 0,  D6, 10);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    1, 1, 0, 0, 1, 0,  D6, 11);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    1, 0, 1, 1, 0, D5, 0,  12);
    add(1, 1, 0, 5, W0,  1, 0, 6, W1,    1, 0, 1, 0, 1, 0,  D6, 13);  // lock restarted from 0
    add(1, 0, 0, 0, 0,   1, 1, 9, DW,    0, 0, 1, 0, 1, 0,  D6, 14);  // m1 write
    add(1, 1, 0, 9, W0,  0, 0, 0, 0,     0, 1, 0, 0, 0, 0,  0,  14);  // m0 read-after-write
    add(1, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 1, 0, DW, 0,  14);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);

    foreach (vecs[i]) begin
      vec_t v;
      logic        e_we;
      logic [9:0]  e_addr;
      logic [31:0] e_wdata;
      string       tag;
      v = vecs[i];
      @(negedge clk);
      rst = v.rs;
      m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1; m1_lock = v.lk;
      #1;
      e_we    = v.g0 ? v.w0 : (v.g1 ? v.w1 : 1'b0);
      e_addr  = v.g0 ? v.a0 : (v.g1 ? v.a1 : 10'd0);
      e_wdata = v.g0 ? v.d0 : (v.g1 ? v.d1 : 32'd0);
      tag = $sformatf("v%0d_", i);
      chk({tag, "m0_gnt"},    {31'd0, m0_gnt},    {31'd0, v.g0});
      chk({tag, "m1_gnt"},    {31'd0, m1_gnt},    {31'd0, v.g1});
      chk({tag, "cpu_stall"}, {31'd0, cpu_stall}, {31'd0, v.r0 & ~v.g0});
      chk({tag, "mem_en"},    {31'd0, mem_en},    {31'd0, v.g0 | v.g1});
      chk({tag, "mem_we"},    {31'd0, mem_we},    {31'd0, e_we});
      chk({tag, "mem_addr"},  {22'd0, mem_addr},  {22'd0, e_addr});
      chk({tag, "mem_wdata"}, mem_wdata,          e_wdata);
      chk({tag, "m0_rvalid"}, {31'd0, m0_rvalid}, {31'd0, v.v0});
      chk({tag, "m1_rvalid"}, {31'd0, m1_rvalid}, {31'd0, v.v1});
      chk({tag, "m0_rdata"},  m0_rdata,           v.rd0);
      chk({tag, "m1_rdata"},  m1_rdata,           v.rd1);
      chk({tag, "conflict"},  {16'd0, conflict_cnt}, {16'd0, v.cnt});
    end

    // Reset lands in the cycle after a granted read: the return must be dropped.
    @(negedge clk);
    idle_inputs();
    m0_req = 1; m0_addr = 10'd5; m0_wdata = W0;
    #1;
    chk("midrst_gnt", {31'd0, m0_gnt}, 32'd1);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("midrst_rvalid_in_rst", {31'd0, m0_rvalid}, 32'd0);
    chk("midrst_rdata_in_rst", m0_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("midrst_rvalid_after_%0d", k), {31'd0, m0_rvalid}, 32'd0);
    end

    // Conflict counter saturation
    @(negedge clk);
    m0_req = 1; m0_addr = 10'd5; m0_wdata = W0;
    m1_req = 1; m1_addr = 10'd6; m1_wdata = W1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sat_fffe", {16'd0, conflict_cnt}, 32'h0000FFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("sat_ffff_%0d", k), {16'd0, conflict_cnt}, 32'h0000FFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
